// File: rtl/pad_out_pkg.sv
// ---------------------------------------------------------------------------
// pad_out_pkg
// Shared definitions for the output pad transmitter:
//   - pad_state_e : transmit FSM states (IDLE, SETUP, STROBE, HOLD)
//   - parityIdx() / strobeIdx() : pin positions of parity and strobe on a
//     pad bus of a given width (data occupies the bits below parity)
//   - PARITY_IDX / STROBE_IDX : those positions for the default 32-pad bus
// ---------------------------------------------------------------------------
package pad_out_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } pad_state_e;

    // Parity sits directly above the data word, strobe is the topmost pin.
    function automatic int parityIdx(input int numPads);
        return numPads - 2;
    endfunction

    function automatic int strobeIdx(input int numPads);
        return numPads - 1;
    endfunction

    localparam int DEFAULT_NUM_OUTPUT_PADS = 32;
    localparam int PARITY_IDX = parityIdx(DEFAULT_NUM_OUTPUT_PADS);
    localparam int STROBE_IDX = strobeIdx(DEFAULT_NUM_OUTPUT_PADS);

endpackage

// File: rtl/pad_out_fifo.sv
// ---------------------------------------------------------------------------
// pad_out_fifo
// Small synchronous FIFO buffering words between the core handshake and the
// pad transmit FSM. DEPTH must be a power of two so the pointers wrap
// naturally.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : write pushData_i (ignored when full)
//   pushData_i   : word to store
//   pop_i        : drop the head word (ignored when empty)
//   popData_o    : current head word, valid while !empty_o
//   full_o       : DEPTH words stored
//   empty_o      : no words stored
//   level_o      : number of words stored
// ---------------------------------------------------------------------------
module pad_out_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               pushData_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               popData_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [LVL_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign doPush    = push_i && !full_o;
    assign doPop     = pop_i && !empty_o;
    assign full_o    = (count_q == LVL_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign level_o   = count_q;
    assign popData_o = mem_q[rdPtr_q];

    // Storage array is not reset: the count decides what is valid, so stale
    // contents are never observed.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    // Pointers wrap modulo DEPTH by overflowing; a simultaneous push and pop
    // leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (doPush && !doPop) begin
                count_q <= count_q + 1'b1;
            end else if (doPop && !doPush) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pad_out_tx.sv
// ---------------------------------------------------------------------------
// pad_out_tx
// Core-side transmitter in front of the chip output pads. Words arrive over a
// valid/ready handshake, are buffered in a FIFO, and are then presented on
// the pads with even parity. Data and parity settle for SETUP_CYCLES before
// the strobe rises, the strobe is held for STROBE_CYCLES, and one HOLD cycle
// follows before the pins may change again.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_data     : word to transmit (DATA_W = NUM_OUTPUT_PADS-2 bits)
//   in_valid    : in_data valid
//   in_ready    : a word can be accepted this cycle
//   output_out  : pad bus {strobe, parity, data}
//   busy        : FIFO non-empty or transmit in progress
//   fifo_level  : words currently buffered
// ---------------------------------------------------------------------------
module pad_out_tx
    import pad_out_pkg::*;
#(
    parameter int NUM_OUTPUT_PADS = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int SETUP_CYCLES    = 2,
    parameter int STROBE_CYCLES   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_OUTPUT_PADS-3:0]        in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [NUM_OUTPUT_PADS-1:0]        output_out,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int DATA_W     = NUM_OUTPUT_PADS - 2;
    localparam int PARITY_PIN = parityIdx(NUM_OUTPUT_PADS);
    localparam int STROBE_PIN = strobeIdx(NUM_OUTPUT_PADS);
    localparam int MAX_PHASE  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int CNT_W      = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);

    if (NUM_OUTPUT_PADS < 3) begin : gBadPads
        $fatal(1, "pad_out_tx: NUM_OUTPUT_PADS must be at least 3");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
        $fatal(1, "pad_out_tx: FIFO_DEPTH must be a power of two >= 2");
    end
    if (SETUP_CYCLES < 1) begin : gBadSetup
        $fatal(1, "pad_out_tx: SETUP_CYCLES must be >= 1");
    end
    if (STROBE_CYCLES < 1) begin : gBadStrobe
        $fatal(1, "pad_out_tx: STROBE_CYCLES must be >= 1");
    end

    pad_state_e          state_q, state_d;
    logic [CNT_W-1:0]    phaseCnt_q, phaseCnt_d;
    logic [DATA_W:0]     outBits_q, outBits_d;
    logic                strobe_q, strobe_d;

    logic                fifoPush;
    logic                fifoPop;
    logic [DATA_W-1:0]   fifoData;
    logic                fifoFull;
    logic                fifoEmpty;

    // Ready comes only from the registered fill count, so a pop in the same
    // cycle never opens a slot early; reset holds the input closed.
    assign in_ready = !rst && !fifoFull;
    assign fifoPush = in_valid && in_ready;
    assign busy     = !fifoEmpty || (state_q != IDLE);

    assign output_out[STROBE_PIN]   = strobe_q;
    assign output_out[PARITY_PIN:0] = outBits_q;

    pad_out_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifoPush),
        .pushData_i (in_data),
        .pop_i      (fifoPop),
        .popData_o  (fifoData),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .level_o    (fifo_level)
    );

    // Next-state logic. A word is popped and latched (with its parity) only
    // when leaving IDLE or HOLD, which is the sole moment the data pins may
    // change. The strobe is registered from the next state so the pad sees a
    // clean flop output.
    always_comb begin
        state_d    = state_q;
        phaseCnt_d = phaseCnt_q;
        outBits_d  = outBits_q;
        fifoPop    = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (!fifoEmpty) begin
                    fifoPop    = 1'b1;
                    outBits_d  = {^fifoData, fifoData};
                    phaseCnt_d = '0;
                    state_d    = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (phaseCnt_q == SETUP_LAST) begin
                    phaseCnt_d = '0;
                    state_d    = STROBE;
                end else begin
                    phaseCnt_d = phaseCnt_q + 1'b1;
                end
            end
            STROBE: begin
                if (phaseCnt_q == STROBE_LAST) begin
                    phaseCnt_d = '0;
                    state_d    = HOLD;
                end else begin
                    phaseCnt_d = phaseCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        strobe_d = (state_d == STROBE);
    end

    // State and pad registers; reset clears the pins and drops any strobe
    // immediately, whatever phase the transfer was in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phaseCnt_q <= '0;
            outBits_q  <= '0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phaseCnt_q <= phaseCnt_d;
            outBits_q  <= outBits_d;
            strobe_q   <= strobe_d;
        end
    end

endmodule

// File: tb/tb_pad_out_tx.sv
// ---------------------------------------------------------------------------
// tb_pad_out_tx
// Self-checking bench for pad_out_tx. Accepted words are queued with their
// hand-computed parity; a monitor compares each word when its strobe rises
// and confirms the pins stay put until the strobe has fallen.
// ---------------------------------------------------------------------------
module tb_pad_out_tx;
    import pad_out_pkg::*;

    localparam int NP    = 32;
    localparam int DW    = NP - 2;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [NP-1:0]   output_out;
    logic            busy;
    logic [2:0]      fifo_level;
    logic            expPar;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [DW:0] expQ[$];

    pad_out_tx #(
        .NUM_OUTPUT_PADS (NP),
        .FIFO_DEPTH      (DEPTH),
        .SETUP_CYCLES    (2),
        .STROBE_CYCLES   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .output_out (output_out),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [DW-1:0] data, input logic par);
        in_data  = data;
        expPar   = par;
        in_valid = 1'b1;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            nextCycle();
            n++;
        end
        checkOutput("drainWithinBudget", busy, 0);
    endtask

    // Record every accepted word with its expected parity; a reset discards
    // everything still buffered.
    always @(posedge clk) begin
        if (rst) begin
            expQ.delete();
        end else if (in_valid && in_ready) begin
            expQ.push_back({expPar, in_data});
        end
    end

    // Compare the pins against the scoreboard when a strobe rises, then watch
    // them through the strobe and the cycle after it falls.
    logic        prevStrobe = 1'b0;
    logic        watching   = 1'b0;
    logic        unstable   = 1'b0;
    logic [DW:0] latched;
    logic [DW:0] expWord;
    always @(negedge clk) begin
        if (rst) begin
            watching = 1'b0;
        end else if (output_out[STROBE_IDX] && !prevStrobe) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpectedWord: got 0x%0h, expected no strobe", output_out[PARITY_IDX:0]);
            end else begin
                expWord = expQ.pop_front();
                checkOutput("strobeWord", output_out[PARITY_IDX:0], expWord);
            end
            latched  = output_out[PARITY_IDX:0];
            watching = 1'b1;
            unstable = 1'b0;
        end else if (watching) begin
            if (output_out[PARITY_IDX:0] !== latched) unstable = 1'b1;
            if (!output_out[STROBE_IDX]) begin
                checkOutput("pinStability", unstable, 0);
                watching = 1'b0;
            end
        end
        prevStrobe = output_out[STROBE_IDX];
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    logic [DW-1:0] b2bWord [4] = '{30'h0000_0F0F, 30'h2AAA_AAAA, 30'h0000_0003, 30'h1000_0001};
    logic          b2bPar  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int            peak;
        int            nRise;
        int            riseC [8];
        logic          prevS;
        logic          gap;
        int            idx;
        int            cyc;
        logic          acc;
        logic          seenFull;
        logic          found;
        logic          sawStrobe;
        logic [31:0]   rnd;
        logic [DW-1:0] rdata;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        expPar   = 1'b0;

        // Reset state
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("resetPins", output_out, 0);
        checkOutput("resetLevel", fifo_level, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetReady", in_ready, 0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterReset", in_ready, 1);

        // Single word: push in cycle 0
        nextCycle();
        applyStimulus(30'h1234_5678, 1'b1);
        nextCycle();
        in_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            case (c)
                1: begin
                    checkOutput("singleLevelC1", fifo_level, 1);
                    checkOutput("singleBusyC1", busy, 1);
                end
                2: begin
                    checkOutput("singleDataC2", output_out[DW-1:0], 30'h1234_5678);
                    checkOutput("singleParityC2", output_out[PARITY_IDX], 1);
                    checkOutput("singleStrobeC2", output_out[STROBE_IDX], 0);
                end
                3: checkOutput("singleStrobeC3", output_out[STROBE_IDX], 0);
                4: checkOutput("singleStrobeC4", output_out[STROBE_IDX], 1);
                5: checkOutput("singleStrobeC5", output_out[STROBE_IDX], 1);
                6: checkOutput("singleStrobeC6", output_out[STROBE_IDX], 0);
                7: checkOutput("singleBusyC7", busy, 0);
                default: ;
            endcase
            nextCycle();
        end
        waitIdle(50);

        // Back-to-back: four pushes in cycles 0..3
        peak  = 0;
        nRise = 0;
        prevS = 1'b0;
        gap   = 1'b0;
        for (int c = 0; c <= 24; c++) begin
            if (c < 4) applyStimulus(b2bWord[c], b2bPar[c]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            if (output_out[STROBE_IDX] && !prevS && nRise < 8) begin
                riseC[nRise] = c;
                nRise++;
            end
            prevS = output_out[STROBE_IDX];
            if (c >= 1 && c <= 21 && !busy) gap = 1'b1;
            nextCycle();
        end
        checkOutput("b2bPeakLevel", peak, 3);
        checkOutput("b2bRiseCount", nRise, 4);
        checkOutput("b2bRise0", riseC[0], 4);
        checkOutput("b2bRise1", riseC[1], 9);
        checkOutput("b2bRise2", riseC[2], 14);
        checkOutput("b2bRise3", riseC[3], 19);
        checkOutput("b2bNoIdleGap", gap, 0);
        waitIdle(50);

        // Backpressure: eight words with in_valid held high
        idx      = 0;
        cyc      = 0;
        seenFull = 1'b0;
        while (idx < 8 && cyc < 200) begin
            applyStimulus(DW'((64'd1 << (idx + 1)) - 1), (idx % 2) == 0);
            @(negedge clk);
            if (fifo_level == 3'd4) begin
                seenFull = 1'b1;
                checkOutput("readyLowWhenFull", in_ready, 0);
            end
            acc = in_ready;
            nextCycle();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("bpAllAccepted", idx, 8);
        checkOutput("bpReachedFull", seenFull, 1);
        waitIdle(200);
        checkOutput("bpAllDelivered", expQ.size(), 0);

        // Parity edges
        applyStimulus(30'h0, 1'b0);
        nextCycle();
        in_valid = 1'b0;
        waitIdle(50);
        checkOutput("parityZero", output_out[PARITY_IDX], 0);
        applyStimulus(30'h3FFF_FFFF, 1'b0);
        nextCycle();
        in_valid = 1'b0;
        waitIdle(50);
        checkOutput("parityAllOnes", output_out[PARITY_IDX], 0);
        applyStimulus(30'h1, 1'b1);
        nextCycle();
        in_valid = 1'b0;
        waitIdle(50);
        checkOutput("parityOne", output_out[PARITY_IDX], 1);

        // Reset during the first strobe cycle with three words queued
        applyStimulus(30'h0111_1111, 1'b1);
        nextCycle();
        applyStimulus(30'h0222_2222, 1'b1);
        nextCycle();
        applyStimulus(30'h0333_3333, 1'b0);
        nextCycle();
        in_valid = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (output_out[STROBE_IDX]) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("rstStrobeSeen", found, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rstPinsCleared", output_out, 0);
        checkOutput("rstLevelCleared", fifo_level, 0);
        checkOutput("rstReadyLow", in_ready, 0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstReadyAfter", in_ready, 1);
        checkOutput("rstNotBusy", busy, 0);
        sawStrobe = 1'b0;
        for (int n = 0; n < 20; n++) begin
            nextCycle();
            if (output_out[STROBE_IDX]) sawStrobe = 1'b1;
        end
        checkOutput("rstNoStaleStrobe", sawStrobe, 0);

        // Random valid pulses, ordering and pin stability checked by the monitor
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 4)) nextCycle();
            rnd   = $urandom;
            rdata = rnd[DW-1:0];
            applyStimulus(rdata, ($countones(rdata) % 2) == 1);
            nextCycle();
            in_valid = 1'b0;
        end
        waitIdle(200);
        checkOutput("randomAllDelivered", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pad_out_tx.md
Name: pad_out_tx

Overview:
- Core-side transmitter that drives the output pad bus `output_out` of the chip top.
- Accepts data words from core logic over a valid/ready handshake and buffers them in a small FIFO.
- Presents each word on the pads with a parity bit and a strobe, timed for slow 30 mA output pads and an external receiver that samples on the strobe.
- Sits inside `chip_core`, directly in front of `output_out`.

Parameters:
- NUM_OUTPUT_PADS, 32, width of the pad bus; DATA_W = NUM_OUTPUT_PADS-2 (localparam, 30 at default).
- FIFO_DEPTH, 4, word buffer depth; power of two, >=2.
- SETUP_CYCLES, 2, cycles data/parity are stable before strobe rises; >=1.
- STROBE_CYCLES, 2, cycles strobe is held high; >=1.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  DATA_W  word to transmit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word.
- output_out  out  NUM_OUTPUT_PADS  pad bus: [DATA_W-1:0] data, [DATA_W] even parity, [DATA_W+1] strobe.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  words currently buffered.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Reset, taking effect at the rising edge while rst=1:
  - output_out=0, FIFO empty, fifo_level=0, busy=0, FSM=IDLE.
  - in_ready=0 while rst is high.
- Handshake:
  - Push occurs on the rising edge with in_valid && in_ready.
  - in_ready = !full, derived from registered count only. When full, in_ready=0 even if a pop happens the same cycle.
  - in_data is ignored when in_valid=0.
- FIFO rules:
  - Simultaneous push and pop (non-full): level unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Parity: output_out[DATA_W] = XOR of data bits (even parity), computed at pop and registered together with the data.
- FSM states:
  - IDLE: strobe=0; data/parity pins keep the last word. If FIFO non-empty: pop, load output register, go to SETUP.
  - SETUP: strobe=0; counts SETUP_CYCLES cycles, then go to STROBE.
  - STROBE: strobe=1; counts STROBE_CYCLES cycles, then go to HOLD.
  - HOLD: strobe=0; one cycle. If FIFO non-empty: pop, load, go to SETUP; else go to IDLE.
- Data/parity pins change only on the edge entering SETUP. They are stable from SETUP entry through HOLD exit.
- Latency (empty FIFO, FSM IDLE): push at the edge ending cycle N.
  - Cycle N+1: pop.
  - Cycle N+2: data on pins.
  - Strobe high cycles N+2+SETUP_CYCLES .. N+1+SETUP_CYCLES+STROBE_CYCLES.
- Throughput: one word per SETUP_CYCLES+STROBE_CYCLES+1 cycles (5 at defaults), back-to-back with no IDLE gap.
- Reset mid-operation (any state): strobe low and pins 0 from the next cycle; buffered words are discarded; no partial strobe is extended.
- Elaboration: the block fails elaboration if any parameter constraint is violated or NUM_OUTPUT_PADS<3.

Decomposition:
- Package pad_out_pkg holds:
  - typedef enum for the FSM states {IDLE, SETUP, STROBE, HOLD};
  - localparams for pin indices (PARITY_IDX, STROBE_IDX) as functions of NUM_OUTPUT_PADS.
- One sub-module: pad_out_fifo, a synchronous FIFO with parameters WIDTH and DEPTH and outputs full, empty and level.
- The FSM, phase counter and output register live in pad_out_tx.

Test Plan:
- Single word: after reset, push 30'h1234_5678 at cycle 0. Expect:
  - output_out[29:0]=30'h1234_5678, parity=1 (13 ones), strobe=0 at cycle 2;
  - strobe=1 at cycles 4-5; strobe=0 at cycle 6;
  - busy=0 at cycle 7.
- Back-to-back: push 4 words in consecutive cycles. Expect:
  - fifo_level peaks at 3;
  - strobes rising at cycles 4, 9, 14, 19 with data in push order;
  - no IDLE cycle between words.
- Backpressure: hold in_valid=1 with 8 words. Expect:
  - in_ready=0 whenever fifo_level=4;
  - all 8 words appear on the pads in order, none dropped or duplicated.
- Parity edges:
  - data=0 → parity=0;
  - data=30'h3FFF_FFFF → parity=0;
  - data=30'h1 → parity=1.
- Reset mid-strobe: with 3 words queued, assert rst during the first STROBE cycle. Expect:
  - next cycle output_out=0, fifo_level=0, in_ready=0;
  - after deassert, in_ready=1 and no stale word is transmitted.
- Stability check: an assertion that data/parity never change while strobe=1 or in the cycle after strobe falls, over 1000 random valid pulses.
